// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: memory-mapped UART receiver with a byte FIFO.
// Deserialises 8N1 frames from i_uart_rx into the FIFO. The CPU drains the FIFO
// through DATA. STATUS/CTRL expose flags and control. o_irq is a registered level.
// Optional feature macro: UART_RX_PARITY_EN selects 8E1 framing with a parity
// check. Without it the frame is 8N1 and STATUS bit4 reads 0.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8,
    parameter int FIFO_AW      = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_sel,
    input  logic        i_we,
    input  logic        i_re,
    input  logic [2:0]  i_addr,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    output logic        o_rdy,
    input  logic        i_uart_rx,
    output logic        o_irq
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]      HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]      FULL_BIT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]      CLK_ONE  = 1;
    localparam logic [FIFO_AW-1:0] PTR_ONE  = 1;
    localparam logic [FIFO_AW:0]   CNT_ONE  = 1;
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} rx_state_t;

    // ---------------- rx front end ----------------
    logic sync1, sync2, sync_d;
    logic rx_s, rx_fall;
    assign rx_s    = sync2;
    assign rx_fall = sync_d & ~sync2;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            sync_d <= 1'b1;
        end else begin
            sync1  <= i_uart_rx;
            sync2  <= sync1;
            sync_d <= sync2;
        end
    end

    // ---------------- rx FSM ----------------
    rx_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             push_req, ferr_set;
    logic             rx_en, irq_en;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_q, par_bad_d, perr_set;
`endif

    // State, bit timer, bit index and shift register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // Next state: mid-bit sampling, push or frame error at the stop bit
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CLK_ONE;
        bit_d    = bit_q;
        shift_d  = shift_q;
        push_req = 1'b0;
        ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_set  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (rx_en && rx_fall) begin
                    state_d = S_START;
                    bit_d   = '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            S_START: begin
                if (cnt_q == HALF_BIT) begin
                    cnt_d   = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_BIT) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == FULL_BIT) begin
                    cnt_d     = '0;
                    state_d   = S_STOP;
                    par_bad_d = ^{shift_q, rx_s};
                    perr_set  = ^{shift_q, rx_s};
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == FULL_BIT) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                        push_req = ~par_bad_q;
`else
                        push_req = 1'b1;
`endif
                    end else begin
                        ferr_set = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Disabling the receiver abandons any frame in flight
        if (!rx_en) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            push_req = 1'b0;
            ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_set = 1'b0;
`endif
        end
    end

    // ---------------- bus decode ----------------
    logic [1:0] reg_sel;
    logic       wr_en, rd_start, wr_sts, wr_ctrl, flush;
    logic       rd_pend, rd_pop;
    assign reg_sel  = i_addr[2:1];
    assign wr_en    = i_sel & i_we;
    assign rd_start = i_sel & i_re & ~rd_pend;
    assign wr_sts   = wr_en & (reg_sel == 2'd1);
    assign wr_ctrl  = wr_en & (reg_sel == 2'd2);
    assign flush    = wr_ctrl & i_wdata[2];
    assign o_rdy    = ~rd_pend;

    // ---------------- FIFO ----------------
    logic [7:0]         mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               not_empty, full, do_pop, do_push, ovr_set;
    logic               overrun, frame_err, parity_err;
    assign not_empty = (count != '0);
    assign full      = (count == CNT_FULL);
    // Flush beats both push and pop; a pop frees a slot for a same-cycle push
    assign do_pop    = rd_pop & not_empty & ~flush;
    assign do_push   = push_req & ~flush & (~full | do_pop);
    assign ovr_set   = push_req & ~flush & full & ~do_pop;

    // Byte storage, no reset needed
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= shift_q;
    end

    // Pointers and occupancy
    always_ff @(posedge i_clk) begin
        if (i_rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags: W1C, a same-cycle set wins over the clear
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= (overrun   & ~(wr_sts & i_wdata[2])) | ovr_set;
            frame_err <= (frame_err & ~(wr_sts & i_wdata[3])) | ferr_set;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Sticky parity error, W1C
    always_ff @(posedge i_clk) begin
        if (i_rst) parity_err <= 1'b0;
        else       parity_err <= (parity_err & ~(wr_sts & i_wdata[4])) | perr_set;
    end
    logic unused_bits;
    assign unused_bits = ^{i_addr[0], i_wdata[15:5]};
`else
    assign parity_err = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{i_addr[0], i_wdata[15:4]};
`endif

    // Control register; flush is a one-cycle strobe and is never stored
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_en  <= 1'b1;
            irq_en <= 1'b0;
        end else if (wr_ctrl) begin
            rx_en  <= i_wdata[0];
            irq_en <= i_wdata[1];
        end
    end

    // ---------------- read path ----------------
    logic [6:0]  count_w;
    logic [3:0]  cnt_disp;
    logic [15:0] rd_mux;
    assign count_w  = 7'(count);
    assign cnt_disp = (count_w > 7'd15) ? 4'hF : count_w[3:0];

    // Read data select for the addressed register
    always_comb begin
        rd_mux = 16'h0000;
        case (reg_sel)
            2'd0: rd_mux = not_empty ? {8'h00, mem[rd_ptr]} : 16'h0000;
            2'd1: rd_mux = {4'h0, cnt_disp, 3'b000, parity_err, frame_err,
                            overrun, full, not_empty};
            2'd2: rd_mux = {14'h0, irq_en, rx_en};
            default: rd_mux = 16'h0000;
        endcase
    end

    // Two-cycle read: capture on the first cycle, pop at the end of the second
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_pend <= 1'b0;
            rd_pop  <= 1'b0;
            o_rdata <= 16'h0000;
        end else if (rd_pend) begin
            rd_pend <= 1'b0;
            rd_pop  <= 1'b0;
        end else if (rd_start) begin
            rd_pend <= 1'b1;
            rd_pop  <= (reg_sel == 2'd0) & not_empty;
            o_rdata <= rd_mux;
        end
    end

    // Registered level interrupt
    always_ff @(posedge i_clk) begin
        if (i_rst) o_irq <= 1'b0;
        else       o_irq <= irq_en & (not_empty | overrun | frame_err | parity_err);
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo, 16 clocks per bit, 4-entry FIFO.
// Bus ops are table-driven; frame timing corner cases are hand-written sequences.
module tb_uart_rx_fifo;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        we  = 1'b0;
    logic        re  = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [15:0] wdata = 16'h0;
    logic [15:0] rdata;
    logic        rdy;
    logic        rx = 1'b1;
    logic        irq;

    int n_chk  = 0;
    int n_fail = 0;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .FIFO_AW(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_we(we), .i_re(re),
        .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata), .o_rdy(rdy),
        .i_uart_rx(rx), .o_irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick(1);
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        int k;
        sel = 1'b1; re = 1'b1; addr = a;
        tick(1);
        chk("rd_rdy_low", {15'h0, rdy}, 16'h0000);
        k = 0;
        while (!rdy && k < 8) begin
            tick(1);
            k++;
        end
        chk("rd_rdy_high", {15'h0, rdy}, 16'h0001);
        d = rdata;
        sel = 1'b0; re = 1'b0;
    endtask

    task automatic read_chk(input string nm, input logic [2:0] a, input logic [15:0] exp);
        logic [15:0] d;
        bus_read(a, d);
        chk(nm, d, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
        rx = 1'b1;
        tick(4);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t t2 [9];
        logic [15:0] d;
        t2[0] = '{1'b0, 3'd2, 16'h0000, 16'h0407};
        t2[1] = '{1'b0, 3'd0, 16'h0000, 16'h0001};
        t2[2] = '{1'b0, 3'd0, 16'h0000, 16'h0002};
        t2[3] = '{1'b0, 3'd0, 16'h0000, 16'h0003};
        t2[4] = '{1'b0, 3'd0, 16'h0000, 16'h0004};
        t2[5] = '{1'b0, 3'd0, 16'h0000, 16'h0000};
        t2[6] = '{1'b0, 3'd2, 16'h0000, 16'h0004};
        t2[7] = '{1'b1, 3'd2, 16'h0004, 16'h0000};
        t2[8] = '{1'b0, 3'd2, 16'h0000, 16'h0000};

        // Reset state
        tick(3);
        rst = 1'b0;
        chk("rst_rdy", {15'h0, rdy}, 16'h0001);
        chk("rst_rdata", rdata, 16'h0000);
        chk("rst_irq", {15'h0, irq}, 16'h0000);
        read_chk("rst_ctrl", 3'd4, 16'h0001);
        read_chk("rst_status", 3'd2, 16'h0000);

        // 1: single byte
        send_byte(8'hA5, 1'b1);
        read_chk("t1_status_pre", 3'd2, 16'h0101);
        read_chk("t1_data", 3'd0, 16'h00A5);
        read_chk("t1_status_post", 3'd2, 16'h0000);

        // 2: overflow then drain, via the vector table
        for (int b = 1; b <= 5; b++) send_byte(8'(b), 1'b1);
        for (int i = 0; i < 9; i++) begin
            if (t2[i].we) bus_write(t2[i].addr, t2[i].wdata);
            else read_chk($sformatf("t2_vec%0d", i), t2[i].addr, t2[i].exp);
        end

        // 3: frame error and interrupt
        send_byte(8'h3C, 1'b0);
        read_chk("t3_status", 3'd2, 16'h0008);
        bus_write(3'd4, 16'h0003);
        chk("t3_irq_w", {15'h0, irq}, 16'h0000);
        tick(1);
        chk("t3_irq_set", {15'h0, irq}, 16'h0001);
        bus_write(3'd2, 16'h0008);
        tick(1);
        chk("t3_irq_clr", {15'h0, irq}, 16'h0000);
        bus_write(3'd4, 16'h0001);

        // 4: short glitch is a false start
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(40);
        read_chk("t4_no_start", 3'd2, 16'h0000);
        send_byte(8'h7E, 1'b1);
        read_chk("t4_status", 3'd2, 16'h0101);
        read_chk("t4_data", 3'd0, 16'h007E);
        read_chk("t4_empty", 3'd2, 16'h0000);

        // 5: pop commits on the same edge the stop bit pushes into a full FIFO
        for (int b = 0; b < 4; b++) send_byte(8'h10 + 8'(b), 1'b1);
        read_chk("t5_full", 3'd2, 16'h0403);
        fork
            send_byte(8'h55, 1'b1);
            begin
                tick(153);
                bus_read(3'd0, d);
                chk("t5_pop", d, 16'h0010);
            end
        join
        read_chk("t5_status", 3'd2, 16'h0403);
        read_chk("t5_d0", 3'd0, 16'h0011);
        read_chk("t5_d1", 3'd0, 16'h0012);
        read_chk("t5_d2", 3'd0, 16'h0013);
        read_chk("t5_last", 3'd0, 16'h0055);
        read_chk("t5_empty", 3'd2, 16'h0000);

        // 6: reset mid-frame with a read pending
        send_byte(8'h99, 1'b1);
        bus_write(3'd4, 16'h0003);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = i[0];
            tick(CPB);
        end
        rx = 1'b1;
        tick(8);
        chk("t6_irq_pre", {15'h0, irq}, 16'h0001);
        sel = 1'b1; re = 1'b1; addr = 3'd0;
        tick(1);
        chk("t6_pend_rdy", {15'h0, rdy}, 16'h0000);
        chk("t6_pend_data", rdata, 16'h0099);
        rst = 1'b1;
        tick(1);
        rst = 1'b0; sel = 1'b0; re = 1'b0; rx = 1'b1;
        chk("t6_rst_rdy", {15'h0, rdy}, 16'h0001);
        chk("t6_rst_rdata", rdata, 16'h0000);
        chk("t6_rst_irq", {15'h0, irq}, 16'h0000);
        tick(200);
        read_chk("t6_status", 3'd2, 16'h0000);
        read_chk("t6_ctrl", 3'd4, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
